pdl_trig_cond: RTL and testbench

Trigger conditioner that sits directly upstream of the programmable delay line and drives its `trigger` input. It synchronises an asynchronous external trigger, rejects glitches shorter than a programmable length, detects rising edges, and emits a single-cycle `trig_out` pulse. A programmable holdoff window and an optional one-shot mode suppress retriggers. It also keeps saturating counts of accepted and rejected triggers.

---
 rtl/pdl_pkg.sv | 16 +
 rtl/pdl_sync_filter.sv | 55 +++++
 rtl/pdl_trig_cond.sv | 86 ++++++++
 tb/tb_pdl_trig_cond.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pdl_pkg.sv
// rtl/pdl_pkg.sv - shared types and default widths for the programmable delay line slice
package pdl_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    HOLD     = 2'd2
  } pdl_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_W_DEF      = 8;
  localparam int HOLD_W_DEF      = 32;
  localparam int CNT_W_DEF       = 16;
  localparam int DL_W            = 32;

endpackage

// File: rtl/pdl_sync_filter.sv
// rtl/pdl_sync_filter.sv - trigger synchroniser, glitch filter and registered rising-edge detect
module pdl_sync_filter
  import pdl_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = FILT_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              trig_in_i,
  input  logic [FILT_W-1:0] filt_len_i,
  output logic              rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   filt_q, filt_d;
  logic                   filt_dly_q;
  logic                   rise_q;
  logic [FILT_W-1:0]      fcnt_q, fcnt_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // >= rather than == so a filt_len lowered mid-count still releases the level
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync != filt_q) begin
      if (fcnt_q >= filt_len_i) begin
        filt_d = sync;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q     <= '0;
      filt_q     <= 1'b0;
      fcnt_q     <= '0;
      filt_dly_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], trig_in_i};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      filt_dly_q <= filt_q;
      rise_q     <= filt_q & ~filt_dly_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/pdl_trig_cond.sv
// rtl/pdl_trig_cond.sv - trigger conditioner: arm/holdoff FSM and saturating event counters
module pdl_trig_cond
  import pdl_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = FILT_W_DEF,
  parameter int HOLD_W      = HOLD_W_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              trig_in_i,
  input  logic              enable_i,
  input  logic              rearm_i,
  input  logic              oneshot_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic [HOLD_W-1:0] holdoff_i,
  output logic              trig_out_o,
  output logic              armed_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  acc_cnt_o,
  output logic [CNT_W-1:0]  rej_cnt_o
);

  pdl_state_e        state_q;
  logic [HOLD_W-1:0] hcnt_q;
  logic              trig_q;
  logic [CNT_W-1:0]  acc_q;
  logic [CNT_W-1:0]  rej_q;
  logic              rise;

  pdl_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_sync_filter (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .trig_in_i  (trig_in_i),
    .filt_len_i (filt_len_i),
    .rise_o     (rise)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= DISARMED;
      hcnt_q  <= '0;
      trig_q  <= 1'b0;
      acc_q   <= '0;
      rej_q   <= '0;
    end else begin
      trig_q <= 1'b0;
      if (!enable_i) begin
        state_q <= DISARMED;
      end else begin
        case (state_q)
          // a candidate arriving with rearm is deliberately dropped
          DISARMED: if (rearm_i) state_q <= ARMED;
          ARMED: begin
            if (rise) begin
              trig_q  <= 1'b1;
              hcnt_q  <= holdoff_i;
              state_q <= HOLD;
              if (acc_q != '1) acc_q <= acc_q + 1'b1;
            end
          end
          HOLD: begin
            if (rise && rej_q != '1) rej_q <= rej_q + 1'b1;
            if (hcnt_q == '0) begin
              state_q <= oneshot_i ? DISARMED : ARMED;
            end else begin
              hcnt_q <= hcnt_q - 1'b1;
            end
          end
          default: state_q <= DISARMED;
        endcase
      end
    end
  end

  assign trig_out_o = trig_q;
  assign armed_o    = (state_q == ARMED);
  assign busy_o     = (state_q == HOLD);
  assign acc_cnt_o  = acc_q;
  assign rej_cnt_o  = rej_q;

endmodule

// File: tb/tb_pdl_trig_cond.sv
// tb/tb_pdl_trig_cond.sv - directed self-checking bench for pdl_trig_cond
module tb_pdl_trig_cond;

  localparam int FILT_W = 8;
  localparam int HOLD_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset, trig_in, enable, rearm, oneshot;
  logic [FILT_W-1:0] filt_len;
  logic [HOLD_W-1:0] holdoff;
  logic              trig_out, armed, busy;
  logic [CNT_W-1:0]  acc_cnt, rej_cnt;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  pdl_trig_cond #(
    .SYNC_STAGES (2),
    .FILT_W      (FILT_W),
    .HOLD_W      (HOLD_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .trig_in_i  (trig_in),
    .enable_i   (enable),
    .rearm_i    (rearm),
    .oneshot_i  (oneshot),
    .filt_len_i (filt_len),
    .holdoff_i  (holdoff),
    .trig_out_o (trig_out),
    .armed_o    (armed),
    .busy_o     (busy),
    .acc_cnt_o  (acc_cnt),
    .rej_cnt_o  (rej_cnt)
  );

  always @(posedge clk) if (trig_out === 1'b1) pulses++;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // caller has just raised trig_in; first step is the sampling edge, n counts edges after it
  task automatic measure(input int limit, output int n);
    step();
    n = 0;
    while (trig_out !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    if (trig_out !== 1'b1) n = -1;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; trig_in = 1'b0; enable = 1'b0; rearm = 1'b0; oneshot = 1'b0;
    filt_len = '0; holdoff = '0;
    steps(2);
    checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL reset_trig_out: got %b expected 0", trig_out); end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %b expected 0", armed); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (acc_cnt !== 4'd0) begin errors++; $display("FAIL reset_acc: got %0d expected 0", acc_cnt); end
    checks++; if (rej_cnt !== 4'd0) begin errors++; $display("FAIL reset_rej: got %0d expected 0", rej_cnt); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int n, h;
    enable = 1'b1; filt_len = 8'd0; holdoff = 32'd10; oneshot = 1'b0;
    rearm = 1'b1; step(); rearm = 1'b0;
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL basic_armed: got %b expected 1", armed); end
    trig_in = 1'b1;
    measure(20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", n); end
    checks++; if (acc_cnt !== 4'd1) begin errors++; $display("FAIL basic_acc: got %0d expected 1", acc_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_with_pulse: got %b expected 1", busy); end
    h = 1;
    step();
    checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b expected 0", trig_out); end
    while (busy === 1'b1 && h < 50) begin
      h++;
      step();
    end
    checks++; if (h !== 11) begin errors++; $display("FAIL basic_hold_len: got %0d expected 11", h); end
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL basic_rearmed: got %b expected 1", armed); end
    trig_in = 1'b0;
    steps(5);
  endtask

  task automatic test_glitch();
    int n, p0;
    filt_len = 8'd3;
    p0 = pulses;
    trig_in = 1'b1; steps(3); trig_in = 1'b0;
    steps(12);
    checks++; if (pulses !== p0) begin errors++; $display("FAIL glitch_no_pulse: got %0d pulses expected %0d", pulses, p0); end
    checks++; if (acc_cnt !== 4'd1) begin errors++; $display("FAIL glitch_acc: got %0d expected 1", acc_cnt); end
    trig_in = 1'b1;
    measure(30, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL glitch_latency: got %0d expected 7", n); end
    checks++; if (acc_cnt !== 4'd2) begin errors++; $display("FAIL glitch_acc2: got %0d expected 2", acc_cnt); end
    trig_in = 1'b0;
    wait_idle(50, n);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle_timeout: got busy %b expected 0", busy); end
    steps(8);
    filt_len = 8'd0;
    steps(2);
  endtask

  task automatic test_holdoff();
    int n, p0;
    holdoff = 32'd20;
    p0 = pulses;
    trig_in = 1'b1;
    measure(20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL hold_latency1: got %0d expected 4", n); end
    checks++; if (acc_cnt !== 4'd3) begin errors++; $display("FAIL hold_acc1: got %0d expected 3", acc_cnt); end
    steps(2); trig_in = 1'b0; steps(3); trig_in = 1'b1;
    steps(10);
    checks++; if (rej_cnt !== 4'd1) begin errors++; $display("FAIL hold_rej: got %0d expected 1", rej_cnt); end
    checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL hold_one_pulse: got %0d expected %0d", pulses, p0 + 1); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_still_busy: got %b expected 1", busy); end
    trig_in = 1'b0;
    wait_idle(60, n);
    steps(3);
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL hold_armed_after: got %b expected 1", armed); end
    trig_in = 1'b1;
    measure(20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL hold_latency2: got %0d expected 4", n); end
    checks++; if (acc_cnt !== 4'd4) begin errors++; $display("FAIL hold_acc2: got %0d expected 4", acc_cnt); end
    trig_in = 1'b0;
    wait_idle(60, n);
    steps(3);
  endtask

  task automatic test_oneshot();
    int n, p0;
    holdoff = 32'd5; oneshot = 1'b1;
    trig_in = 1'b1;
    measure(20, n);
    checks++; if (acc_cnt !== 4'd5) begin errors++; $display("FAIL os_acc1: got %0d expected 5", acc_cnt); end
    trig_in = 1'b0;
    wait_idle(30, n);
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL os_disarmed: got %b expected 0", armed); end
    p0 = pulses;
    trig_in = 1'b1; steps(10);
    checks++; if (pulses !== p0) begin errors++; $display("FAIL os_ignored_pulse: got %0d expected %0d", pulses, p0); end
    checks++; if (acc_cnt !== 4'd5 || rej_cnt !== 4'd1) begin errors++; $display("FAIL os_counts: got acc %0d rej %0d expected 5 1", acc_cnt, rej_cnt); end
    trig_in = 1'b0; steps(4);
    rearm = 1'b1; step(); rearm = 1'b0;
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL os_rearm: got %b expected 1", armed); end
    trig_in = 1'b1;
    measure(20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL os_latency: got %0d expected 4", n); end
    checks++; if (acc_cnt !== 4'd6) begin errors++; $display("FAIL os_acc2: got %0d expected 6", acc_cnt); end
    oneshot = 1'b0; trig_in = 1'b0;
    wait_idle(30, n);
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL os_sampled_at_exit: got %b expected 1", armed); end
    steps(3);
  endtask

  task automatic test_abort();
    int n;
    holdoff = 32'd20;
    trig_in = 1'b1;
    measure(20, n);
    checks++; if (acc_cnt !== 4'd7) begin errors++; $display("FAIL abort_acc: got %0d expected 7", acc_cnt); end
    steps(3);
    enable = 1'b0; step();
    checks++; if (busy !== 1'b0 || armed !== 1'b0) begin errors++; $display("FAIL abort_disarm: got busy %b armed %b expected 0 0", busy, armed); end
    enable = 1'b1; trig_in = 1'b0; steps(4);
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL abort_stays_disarmed: got %b expected 0", armed); end
    trig_in = 1'b1; steps(4);
    rearm = 1'b1; step(); rearm = 1'b0;
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL simul_armed: got %b expected 1", armed); end
    checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL simul_no_pulse: got %b expected 0", trig_out); end
    steps(3);
    checks++; if (acc_cnt !== 4'd7 || busy !== 1'b0) begin errors++; $display("FAIL simul_after: got acc %0d busy %b expected 7 0", acc_cnt, busy); end
    trig_in = 1'b0; steps(4);
  endtask

  task automatic test_saturation_reset();
    int n, p0;
    holdoff = 32'd2000;
    trig_in = 1'b1;
    measure(20, n);
    checks++; if (acc_cnt !== 4'd8) begin errors++; $display("FAIL sat_acc: got %0d expected 8", acc_cnt); end
    for (int i = 0; i < 20; i++) begin
      trig_in = 1'b0; steps(2);
      trig_in = 1'b1; steps(2);
    end
    steps(4);
    checks++; if (rej_cnt !== 4'd15) begin errors++; $display("FAIL sat_rej: got %0d expected 15", rej_cnt); end
    checks++; if (busy !== 1'b1 || acc_cnt !== 4'd8) begin errors++; $display("FAIL sat_state: got busy %b acc %0d expected 1 8", busy, acc_cnt); end
    reset = 1'b1; step();
    checks++; if (busy !== 1'b0 || armed !== 1'b0 || trig_out !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got busy %b armed %b trig %b expected 0 0 0", busy, armed, trig_out); end
    checks++; if (acc_cnt !== 4'd0 || rej_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_counts: got acc %0d rej %0d expected 0 0", acc_cnt, rej_cnt); end
    steps(2); reset = 1'b0;
    p0 = pulses;
    steps(8);
    checks++; if (pulses !== p0 || acc_cnt !== 4'd0 || armed !== 1'b0) begin errors++; $display("FAIL rst_trig_high: got pulses %0d acc %0d armed %b expected %0d 0 0", pulses, acc_cnt, armed, p0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_holdoff();
    test_oneshot();
    test_abort();
    test_saturation_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
